// File: rtl/rf_port_arbiter.sv
// Round-robin arbiter sharing the 8x8 register file's write port and dual read
// ports between NUM_REQ requesters, with a lock for read-modify-write and a lock watchdog.
module rf_port_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int LOCK_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [3*NUM_REQ-1:0]   req_addr_a,
    input  logic [3*NUM_REQ-1:0]   req_addr_b,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [7:0]             rsp_data_a,
    output logic [7:0]             rsp_data_b,
    output logic                   lock_err,
    output logic                   rf_wrt_en,
    output logic [2:0]             rf_rd,
    output logic [7:0]             rf_dat,
    output logic [2:0]             rf_rs,
    output logic [2:0]             rf_rs2,
    input  logic [7:0]             rf_rs_o,
    input  logic [7:0]             rf_rs2_o
);

    localparam int IW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t          r_state;
    lock_state_t          w_state_n;
    logic [IW-1:0]        r_rr_ptr;
    logic [IW-1:0]        w_rr_n;
    logic [IW-1:0]        r_owner;
    logic [IW-1:0]        w_owner_n;
    logic [7:0]           r_idle_cnt;
    logic [7:0]           w_idle_n;
    logic [NUM_REQ-1:0]   r_pend;
    logic [NUM_REQ-1:0]   w_pend_n;
    logic                 r_lock_err;
    logic                 w_lock_err_n;

    logic                 w_hs;
    logic [IW-1:0]        w_gidx;
    logic [NUM_REQ-1:0]   w_grant;
    int                   w_scan;

    function automatic logic [IW-1:0] wrapInc(input logic [IW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1)
            return '0;
        else
            return idx + 1'b1;
    endfunction

    // Scan downward in offset so the requester closest to rr_ptr is the last writer and wins.
    always_comb begin
        w_hs    = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        w_scan  = 0;
        if (r_state == LOCKED) begin
            if (req_valid[r_owner]) begin
                w_hs   = 1'b1;
                w_gidx = r_owner;
            end
        end else begin
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                w_scan = int'(r_rr_ptr) + k;
                if (w_scan >= NUM_REQ)
                    w_scan = w_scan - NUM_REQ;
                if (req_valid[w_scan]) begin
                    w_hs   = 1'b1;
                    w_gidx = IW'(w_scan);
                end
            end
        end
        if (w_hs)
            w_grant[w_gidx] = 1'b1;
    end

    assign req_ready = w_grant;

    always_comb begin
        rf_wrt_en = 1'b0;
        rf_rd     = 3'd0;
        rf_dat    = 8'd0;
        rf_rs     = 3'd0;
        rf_rs2    = 3'd0;
        if (w_hs) begin
            rf_wrt_en = req_we[w_gidx];
            rf_rd     = req_addr_a[int'(w_gidx)*3 +: 3];
            rf_rs     = req_addr_a[int'(w_gidx)*3 +: 3];
            rf_rs2    = req_addr_b[int'(w_gidx)*3 +: 3];
            rf_dat    = req_wdata[int'(w_gidx)*8 +: 8];
        end
    end

    // Lock FSM: rr_ptr only advances on unlocked handshakes and is re-seeded past the owner on release.
    always_comb begin
        w_state_n    = r_state;
        w_rr_n       = r_rr_ptr;
        w_owner_n    = r_owner;
        w_idle_n     = r_idle_cnt;
        w_lock_err_n = 1'b0;
        w_pend_n     = (w_hs && !req_we[w_gidx]) ? w_grant : '0;
        case (r_state)
            UNLOCKED: begin
                if (w_hs) begin
                    w_rr_n = wrapInc(w_gidx);
                    if (req_lock[w_gidx]) begin
                        w_state_n = LOCKED;
                        w_owner_n = w_gidx;
                        w_idle_n  = 8'd0;
                    end
                end
            end
            LOCKED: begin
                if (w_hs) begin
                    w_idle_n = 8'd0;
                    if (!req_lock[w_gidx]) begin
                        w_state_n = UNLOCKED;
                        w_rr_n    = wrapInc(r_owner);
                    end
                end else if (r_idle_cnt == 8'(LOCK_MAX - 1)) begin
                    w_state_n    = UNLOCKED;
                    w_idle_n     = 8'd0;
                    w_lock_err_n = 1'b1;
                    w_rr_n       = wrapInc(r_owner);
                end else begin
                    w_idle_n = r_idle_cnt + 8'd1;
                end
            end
            default: begin
                w_state_n = UNLOCKED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= UNLOCKED;
            r_rr_ptr   <= '0;
            r_owner    <= '0;
            r_idle_cnt <= 8'd0;
            r_pend     <= '0;
            r_lock_err <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_rr_ptr   <= w_rr_n;
            r_owner    <= w_owner_n;
            r_idle_cnt <= w_idle_n;
            r_pend     <= w_pend_n;
            r_lock_err <= w_lock_err_n;
        end
    end

    // Read data arrives from the register file one cycle after the handshake, aligned with r_pend.
    assign rsp_valid  = r_pend;
    assign rsp_data_a = (|r_pend) ? rf_rs_o  : 8'h00;
    assign rsp_data_b = (|r_pend) ? rf_rs2_o : 8'h00;
    assign lock_err   = r_lock_err;

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single write port and dual read port of the 8x8 CPU register file between NUM_REQ requesters (e.g. core writeback, load unit, debug port).
- Grants one request per cycle using round-robin and drives the register file address, data and write-enable lines.
- Returns read data with the register file's 1-cycle registered-read latency.
- Supports a lock so one requester can hold the file for a read-modify-write sequence, with a watchdog timeout on the lock.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- LOCK_MAX, 15, consecutive idle cycles a lock owner may hold the lock before forced release (1..255).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  grant; a handshake occurs on a cycle where valid and ready are both 1
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_lock  in  NUM_REQ  acquire or keep the lock with this request
- req_addr_a  in  3*NUM_REQ  read address A, or write destination; requester i uses slice [3i+2:3i]
- req_addr_b  in  3*NUM_REQ  read address B (ignored for writes)
- req_wdata  in  8*NUM_REQ  write data; requester i uses slice [8i+7:8i]
- rsp_valid  out  NUM_REQ  read response valid, one bit per requester
- rsp_data_a  out  8  shared read data A
- rsp_data_b  out  8  shared read data B
- rf_wrt_en  out  1  register file write enable
- rf_rd  out  3  register file write address
- rf_dat  out  8  register file write data
- rf_rs  out  3  register file read address A
- rf_rs2  out  3  register file read address B
- rf_rs_o  in  8  register file registered read data A
- rf_rs2_o  in  8  register file registered read data B

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge. On reset:
  - state is UNLOCKED, rr pointer is 0, owner is 0, idle counter is 0, pending-read register is cleared.
  - rsp_valid is 0 and lock_err is 0.
  - req_ready and all rf_* outputs evaluate to 0 while no request is valid.
- Grant is combinational from registered state:
  - UNLOCKED: grant goes to the first valid requester scanning from rr_ptr upward, modulo NUM_REQ.
  - LOCKED: only the owner can be granted; all other ready bits are 0.
  - At most one req_ready bit is high per cycle. req_ready never depends on req_ready.
- Register file drive (combinational from the granted requester):
  - rf_rs and rf_rd come from addr_a; rf_rs2 comes from addr_b; rf_dat comes from wdata.
  - rf_wrt_en = handshake AND req_we. With no grant, all rf_* outputs are 0.
- Reads:
  - A read handshake in cycle N makes rsp_valid[i] = 1 in cycle N+1, for exactly 1 cycle.
  - In cycle N+1, rsp_data_a = rf_rs_o and rsp_data_b = rf_rs2_o.
  - With no response, rsp_data_a and rsp_data_b are 0.
  - Back-to-back reads yield one response per cycle.
  - A read in cycle N+1 of a register written in cycle N returns the new value.
- Writes produce no response. The register file is updated at the handshake edge.
- Round-robin: on each handshake in UNLOCKED, rr_ptr <= grant index + 1 (mod NUM_REQ). rr_ptr is frozen while LOCKED.
- Lock FSM:
  - UNLOCKED -> LOCKED on a handshake with req_lock = 1; owner <= the granted index.
  - LOCKED -> UNLOCKED on an owner handshake with req_lock = 0. That handshake still executes. rr_ptr <= owner + 1.
  - LOCKED, idle: each cycle in which the owner's req_valid = 0 increments idle_cnt. Any owner handshake clears idle_cnt.
  - Timeout: when idle_cnt reaches LOCK_MAX, the block returns to UNLOCKED, pulses lock_err for 1 cycle, and sets rr_ptr <= owner + 1.
  - lock_err is an additional 1-bit output, appended after rsp_data_b.
- Boundaries:
  - Simultaneous requests from all requesters: only the rr winner is served; the others wait, and req_valid must stay asserted.
  - Lock owner deasserts valid: the other requesters stay blocked until unlock or timeout.
  - rst asserted mid-operation: a pending response is dropped (rsp_valid forced to 0) and the lock is released.
  - rr_ptr wraps from NUM_REQ-1 to 0.

Test Plan:
- Reset, then requester 0 writes 8'hA5 to reg 3 and then reads A=3, B=0 -> rf_wrt_en = 1 for 1 cycle; rsp_valid[0] asserts the cycle after the read handshake with rsp_data_a = 8'hA5, rsp_data_b = 8'h00.
- Both requesters hold continuous read requests for 6 cycles -> grants alternate 0,1,0,1,0,1 starting at requester 0; 6 responses return in order.
- Requester 1 writes reg 5 = 8'h3C in cycle N, requester 0 reads reg 5 in cycle N+1 -> requester 0's response data_a = 8'h3C.
- Requester 1 handshakes a read with lock = 1, requester 0 is continuously valid, requester 1 then writes with lock = 0 after 3 cycles -> req_ready[0] = 0 throughout, then requester 0 is granted the next cycle.
- Requester 0 locks, then idles with LOCK_MAX = 15 -> lock_err pulses after 15 idle cycles, and the pending requester 1 is granted the following cycle.
- Assert rst in the cycle after a read handshake -> rsp_valid stays 0, and after release a request from requester 1 wins with rr_ptr = 0 semantics.
